// File: rtl/key_hold_meter.sv
// key_hold_meter
// Reads an active-low push-button, synchronizes and debounces it, then
// measures how many whole seconds it was held. On release the duration is
// reported as a saturated level (0..MAX_LEVEL) with a one-cycle strobe and
// as a 4-bit thermometer on the LEDs.
//
// Build option: define KEY_HOLD_LIVE_EN to have the LEDs show the live
// seconds count while the key is held. The default build only updates the
// LEDs when a press completes.

module key_hold_meter #(
    parameter int TICK_CYCLES     = 12_000_000,
    parameter int DEBOUNCE_CYCLES = 240_000,
    parameter int MAX_LEVEL       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_n,
    output logic       pressed,
    output logic [2:0] level,
    output logic       level_valid,
    output logic [3:0] led
);

    // Counter widths; guarded so a degenerate parameter of 1 still yields a
    // legal one-bit counter.
    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]        SEC_MAX   = 3'(MAX_LEVEL);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;

    logic              key_meta_reg;
    logic              key_s_reg;
    logic              key_db_reg;
    logic [DB_W-1:0]   db_cnt_reg;

    logic [1:0]        state_reg;
    logic [1:0]        state_next;
    logic [TICK_W-1:0] tick_reg;
    logic [TICK_W-1:0] tick_next;
    logic [2:0]        sec_reg;
    logic [2:0]        sec_next;
    logic [2:0]        level_reg;
    logic [2:0]        level_next;
    logic [3:0]        led_reg;
    logic [3:0]        led_next;

    logic              tick_wrap;
    logic [2:0]        sec_adv;
    logic [3:0]        thermo_adv;

    // Two-flop synchronizer; resets to the released level so a held key is
    // seen as a fresh press after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_meta_reg <= 1'b1;
            key_s_reg    <= 1'b1;
        end else begin
            key_meta_reg <= key_n;
            key_s_reg    <= key_meta_reg;
        end
    end

    // Debouncer: accept a new key level only after it has differed from the
    // accepted level for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_db_reg <= 1'b1;
            db_cnt_reg <= '0;
        end else if (key_s_reg == key_db_reg) begin
            db_cnt_reg <= '0;
        end else if (db_cnt_reg == DB_LAST) begin
            key_db_reg <= key_s_reg;
            db_cnt_reg <= '0;
        end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
        end
    end

    // Seconds count as it will stand after this cycle's tick, saturating.
    // The release cycle still counts, so level reflects every HOLD cycle.
    assign tick_wrap = (tick_reg == TICK_LAST);
    assign sec_adv   = (tick_wrap && (sec_reg < SEC_MAX)) ? sec_reg + 3'd1 : sec_reg;

    // Thermometer of the advanced seconds count: led[i] lit iff count > i.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_thermo
            assign thermo_adv[gi] = (sec_adv > 3'(gi));
        end
    endgenerate

    // FSM next-state and datapath: IDLE waits for a debounced press, HOLD
    // counts ticks and seconds, REPORT is the one-cycle result strobe.
    always_comb begin
        state_next = state_reg;
        tick_next  = tick_reg;
        sec_next   = sec_reg;
        level_next = level_reg;
        led_next   = led_reg;
        case (state_reg)
            ST_IDLE: begin
                tick_next = '0;
                sec_next  = '0;
                if (!key_db_reg) begin
                    state_next = ST_HOLD;
`ifdef KEY_HOLD_LIVE_EN
                    led_next   = 4'b0000;
`endif
                end
            end
            ST_HOLD: begin
                tick_next = tick_wrap ? '0 : tick_reg + 1'b1;
                sec_next  = sec_adv;
`ifdef KEY_HOLD_LIVE_EN
                led_next  = thermo_adv;
`endif
                if (key_db_reg) begin
                    state_next = ST_REPORT;
                    level_next = sec_adv;
                    led_next   = thermo_adv;
                end
            end
            ST_REPORT: begin
                tick_next  = '0;
                sec_next   = '0;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM and result registers; reset mid-press drops the press silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            tick_reg  <= '0;
            sec_reg   <= '0;
            level_reg <= '0;
            led_reg   <= '0;
        end else begin
            state_reg <= state_next;
            tick_reg  <= tick_next;
            sec_reg   <= sec_next;
            level_reg <= level_next;
            led_reg   <= led_next;
        end
    end

    assign pressed     = (state_reg == ST_HOLD);
    assign level_valid = (state_reg == ST_REPORT);
    assign level       = level_reg;
    assign led         = led_reg;

endmodule

// File: tb/tb_key_hold_meter.sv
// Directed testbench for key_hold_meter with DEBOUNCE_CYCLES=4 and
// TICK_CYCLES=100. Key edges are applied 1 ns after a rising edge; outputs
// are sampled 1 ns after a rising edge. With that alignment a key_n fall
// gives pressed=1 seven edges later, and a release gives level_valid=1
// seven edges after the release. A press held for D edges reports
// floor(D/100) saturated at 4.

module tb_key_hold_meter;

    logic       clk;
    logic       rst_n;
    logic       key_n;
    logic       pressed;
    logic [2:0] level;
    logic       level_valid;
    logic [3:0] led;

    int total;
    int bad;
    int strobe_cnt;
    int s0;

`ifdef KEY_HOLD_LIVE_EN
    localparam bit LIVE = 1'b1;
`else
    localparam bit LIVE = 1'b0;
`endif

    key_hold_meter #(
        .TICK_CYCLES    (100),
        .DEBOUNCE_CYCLES(4),
        .MAX_LEVEL      (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_n      (key_n),
        .pressed    (pressed),
        .level      (level),
        .level_valid(level_valid),
        .led        (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count strobe cycles mid-cycle so every high cycle is seen once.
    always @(negedge clk) begin
        if (level_valid === 1'b1) strobe_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        total++; if (pressed !== 1'b0) begin bad++; $display("FAIL reset_pressed: got %b want 0", pressed); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
        total++; if (level_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", level_valid); end
        total++; if (led !== 4'b0000) begin bad++; $display("FAIL reset_led: got %b want 0000", led); end
        step(50);
        total++; if ({pressed, level, level_valid, led} !== 9'd0) begin bad++; $display("FAIL idle50_outputs: got %b want 000000000", {pressed, level, level_valid, led}); end
        total++; if (strobe_cnt !== 0) begin bad++; $display("FAIL idle50_strobes: got %0d want 0", strobe_cnt); end
        $display("test_reset: done");
    endtask

    task automatic test_bounce();
        s0 = strobe_cnt;
        key_n = 1'b0;
        step(3);
        key_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            total++; if (pressed !== 1'b0) begin bad++; $display("FAIL bounce_pressed: cycle %0d got %b want 0", i, pressed); end
        end
        total++; if (strobe_cnt - s0 !== 0) begin bad++; $display("FAIL bounce_strobes: got %0d want 0", strobe_cnt - s0); end
        $display("test_bounce: done");
    endtask

    task automatic test_short_press();
        s0 = strobe_cnt;
        key_n = 1'b0;
        step(4);
        key_n = 1'b1;
        step(6);
        total++; if (pressed !== 1'b1 || level_valid !== 1'b0) begin bad++; $display("FAIL short_hold: got pressed=%b valid=%b want 1 0", pressed, level_valid); end
        step(1);
        total++; if (level_valid !== 1'b1 || level !== 3'd0 || led !== 4'b0000) begin bad++; $display("FAIL short_report: got valid=%b level=%0d led=%b want 1 0 0000", level_valid, level, led); end
        step(1);
        total++; if (level_valid !== 1'b0) begin bad++; $display("FAIL short_width: got %b want 0", level_valid); end
        total++; if (strobe_cnt - s0 !== 1) begin bad++; $display("FAIL short_strobes: got %0d want 1", strobe_cnt - s0); end
        $display("test_short_press: level=%0d", level);
    endtask

    task automatic test_hold_two();
        s0 = strobe_cnt;
        key_n = 1'b0;
        step(6);
        total++; if (pressed !== 1'b0) begin bad++; $display("FAIL press_latency_early: got %b want 0", pressed); end
        step(1);
        total++; if (pressed !== 1'b1) begin bad++; $display("FAIL press_latency: got %b want 1", pressed); end
        step(50);
        total++; if (led !== 4'b0000) begin bad++; $display("FAIL hold2_led_50: got %b want 0000", led); end
        step(100);
        total++; if (led !== (LIVE ? 4'b0001 : 4'b0000)) begin bad++; $display("FAIL hold2_led_150: got %b want %b", led, (LIVE ? 4'b0001 : 4'b0000)); end
        step(70);
        total++; if (led !== (LIVE ? 4'b0011 : 4'b0000)) begin bad++; $display("FAIL hold2_led_220: got %b want %b", led, (LIVE ? 4'b0011 : 4'b0000)); end
        step(23);
        key_n = 1'b1;
        step(6);
        total++; if (pressed !== 1'b1 || level_valid !== 1'b0) begin bad++; $display("FAIL hold2_prerelease: got pressed=%b valid=%b want 1 0", pressed, level_valid); end
        step(1);
        total++; if (pressed !== 1'b0 || level_valid !== 1'b1) begin bad++; $display("FAIL hold2_edge: got pressed=%b valid=%b want 0 1", pressed, level_valid); end
        total++; if (level !== 3'd2 || led !== 4'b0011) begin bad++; $display("FAIL hold2_result: got level=%0d led=%b want 2 0011", level, led); end
        step(1);
        total++; if (level_valid !== 1'b0) begin bad++; $display("FAIL hold2_width: got %b want 0", level_valid); end
        total++; if (strobe_cnt - s0 !== 1) begin bad++; $display("FAIL hold2_strobes: got %0d want 1", strobe_cnt - s0); end
        step(3);
        total++; if (level !== 3'd2 || led !== 4'b0011) begin bad++; $display("FAIL hold2_retain: got level=%0d led=%b want 2 0011", level, led); end
        $display("test_hold_two: level=%0d led=%b", level, led);
    endtask

    task automatic test_glitch();
        s0 = strobe_cnt;
        key_n = 1'b0;
        step(100);
        key_n = 1'b1;
        step(2);
        key_n = 1'b0;
        step(10);
        total++; if (pressed !== 1'b1) begin bad++; $display("FAIL glitch_pressed: got %b want 1", pressed); end
        step(138);
        key_n = 1'b1;
        step(8);
        total++; if (strobe_cnt - s0 !== 1) begin bad++; $display("FAIL glitch_strobes: got %0d want 1", strobe_cnt - s0); end
        total++; if (level !== 3'd2 || led !== 4'b0011) begin bad++; $display("FAIL glitch_result: got level=%0d led=%b want 2 0011", level, led); end
        $display("test_glitch: level=%0d", level);
    endtask

    task automatic test_long();
        s0 = strobe_cnt;
        key_n = 1'b0;
        step(457);
        total++; if (led !== (LIVE ? 4'b1111 : 4'b0011)) begin bad++; $display("FAIL long_led_450: got %b want %b", led, (LIVE ? 4'b1111 : 4'b0011)); end
        step(543);
        key_n = 1'b1;
        step(7);
        total++; if (level_valid !== 1'b1 || level !== 3'd4 || led !== 4'b1111) begin bad++; $display("FAIL long_result: got valid=%b level=%0d led=%b want 1 4 1111", level_valid, level, led); end
        #5;
        total++; if (strobe_cnt - s0 !== 1) begin bad++; $display("FAIL long_strobes: got %0d want 1", strobe_cnt - s0); end
        $display("test_long: level=%0d led=%b", level, led);
    endtask

    // Starts while the previous REPORT cycle is still active.
    task automatic test_back_to_back();
        s0 = strobe_cnt;
        key_n = 1'b0;
        step(6);
        total++; if (pressed !== 1'b0) begin bad++; $display("FAIL b2b_early: got %b want 0", pressed); end
        step(1);
        total++; if (pressed !== 1'b1) begin bad++; $display("FAIL b2b_pressed: got %b want 1", pressed); end
        step(50);
        total++; if (led !== (LIVE ? 4'b0000 : 4'b1111)) begin bad++; $display("FAIL b2b_led_50: got %b want %b", led, (LIVE ? 4'b0000 : 4'b1111)); end
        step(63);
        key_n = 1'b1;
        step(7);
        total++; if (level_valid !== 1'b1 || level !== 3'd1 || led !== 4'b0001) begin bad++; $display("FAIL b2b_result: got valid=%b level=%0d led=%b want 1 1 0001", level_valid, level, led); end
        step(1);
        total++; if (strobe_cnt - s0 !== 1) begin bad++; $display("FAIL b2b_strobes: got %0d want 1", strobe_cnt - s0); end
        $display("test_back_to_back: level=%0d", level);
    endtask

    task automatic test_reset_mid_press();
        s0 = strobe_cnt;
        step(5);
        key_n = 1'b0;
        step(157);
        total++; if (pressed !== 1'b1) begin bad++; $display("FAIL rmp_pressed: got %b want 1", pressed); end
        rst_n = 1'b0;
        step(1);
        total++; if ({pressed, level, level_valid, led} !== 9'd0) begin bad++; $display("FAIL rmp_cleared: got %b want 000000000", {pressed, level, level_valid, led}); end
        rst_n = 1'b1;
        step(6);
        total++; if (pressed !== 1'b0) begin bad++; $display("FAIL rmp_repress_early: got %b want 0", pressed); end
        step(1);
        total++; if (pressed !== 1'b1) begin bad++; $display("FAIL rmp_repress: got %b want 1", pressed); end
        step(143);
        key_n = 1'b1;
        step(7);
        total++; if (level_valid !== 1'b1 || level !== 3'd1 || led !== 4'b0001) begin bad++; $display("FAIL rmp_result: got valid=%b level=%0d led=%b want 1 1 0001", level_valid, level, led); end
        step(1);
        total++; if (strobe_cnt - s0 !== 1) begin bad++; $display("FAIL rmp_strobes: got %0d want 1", strobe_cnt - s0); end
        $display("test_reset_mid_press: level=%0d", level);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        strobe_cnt = 0;
        s0         = 0;
        rst_n      = 1'b0;
        key_n      = 1'b1;
        step(3);
        rst_n = 1'b1;
        test_reset();
        test_bounce();
        test_short_press();
        test_hold_two();
        test_glitch();
        test_long();
        test_back_to_back();
        test_reset_mid_press();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
